// File: rtl/avalon_word_responder.sv
// avalon_word_responder: Avalon-MM responder for a window of 16-bit words.
// Inserts WAIT_CYCLES of waitrequest before every acceptance, returns read
// data through a fixed READ_LATENCY pipeline, counts accepted in-range
// writes and flags out-of-range or malformed requests in a sticky err bit.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no request being stalled; stall count is implicitly 0
// S_STALL | a request is held; r_stall_cnt wait cycles already inserted
module avalon_word_responder #(
  parameter logic [31:0] ADDR_BASE    = 32'd400_000,
  parameter int          DEPTH        = 256,
  parameter int          WAIT_CYCLES  = 1,
  parameter int          READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic [1:0]  byteenable,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] address,
  input  logic [15:0] writedata,
  output logic        waitrequest,
  output logic        readdatavalid,
  output logic [15:0] readdata,
  output logic [15:0] write_count,
  output logic        err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {S_IDLE, S_STALL} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_stall_cnt;
  logic [3:0]  w_stall_cnt_nxt;
  logic [3:0]  w_stall_cur;

  logic        w_req;
  logic        w_illegal;
  logic        w_accept;
  logic        w_rd_acc;
  logic        w_wr_acc;

  logic [31:0] w_word_off;
  logic        w_in_range;
  logic [IW-1:0] w_idx;
  logic [15:0] w_rd_word;

  logic [15:0] r_mem [DEPTH];

  logic [READ_LATENCY-1:0] r_pipe_vld;
  logic [15:0]             r_pipe_data [READ_LATENCY];

  logic [15:0] r_write_count;
  logic        r_err;

  assign w_req     = chipselect & (read_n ^ write_n);
  assign w_illegal = chipselect & ~read_n & ~write_n;

  // Address decode; the index is forced to 0 when out of range so the
  // memory is never looked up past its last word.
  assign w_word_off = (address - ADDR_BASE) >> 1;
  assign w_in_range = (address >= ADDR_BASE) && !address[0] &&
                      (w_word_off < 32'(DEPTH));
  assign w_idx      = w_in_range ? w_word_off[IW-1:0] : '0;
  assign w_rd_word  = w_in_range ? r_mem[w_idx] : 16'hDEAD;

  // Stall decision and next-state: a held request past acceptance falls
  // back to IDLE and is treated as a fresh request on the following edge.
  always_comb begin
    w_stall_cur     = (r_state == S_STALL) ? r_stall_cnt : 4'd0;
    waitrequest     = reset | (w_req & (w_stall_cur < 4'(WAIT_CYCLES)));
    w_accept        = w_req & ~waitrequest;
    w_rd_acc        = w_accept & ~read_n;
    w_wr_acc        = w_accept & ~write_n;
    w_state_nxt     = S_IDLE;
    w_stall_cnt_nxt = 4'd0;
    if (w_req && !w_accept) begin
      w_state_nxt     = S_STALL;
      w_stall_cnt_nxt = w_stall_cur + 4'd1;
    end
  end

  // Stall FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_stall_cnt <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
    end
  end

  // Word storage with per-byte write enables; deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc && w_in_range) begin
      if (byteenable[0]) r_mem[w_idx][7:0]  <= writedata[7:0];
      if (byteenable[1]) r_mem[w_idx][15:8] <= writedata[15:8];
    end
  end

  // Read response pipeline: stage 0 loads at the accepting edge, the last
  // stage drives readdatavalid/readdata.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pipe_vld <= '0;
      for (int i = 0; i < READ_LATENCY; i++) r_pipe_data[i] <= 16'd0;
    end else begin
      r_pipe_vld[0] <= w_rd_acc;
      if (w_rd_acc) r_pipe_data[0] <= w_rd_word;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_data[i] <= r_pipe_data[i-1];
      end
    end
  end

  // Saturating write counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_write_count <= 16'd0;
      r_err         <= 1'b0;
    end else begin
      if (w_wr_acc && w_in_range && (r_write_count != 16'hFFFF))
        r_write_count <= r_write_count + 16'd1;
      if (w_illegal || (w_accept && !w_in_range))
        r_err <= 1'b1;
    end
  end

  assign readdatavalid = r_pipe_vld[READ_LATENCY-1];
  assign readdata      = r_pipe_data[READ_LATENCY-1];
  assign write_count   = r_write_count;
  assign err           = r_err;

endmodule

// File: tb/tb_avalon_word_responder.sv
// Testbench for avalon_word_responder: default instance driven through
// directed and random scenarios against a word-level memory model, plus a
// zero-wait / latency-3 instance for streaming reads.
module tb_avalon_word_responder;

  localparam logic [31:0] BASE  = 32'd400_000;
  localparam int          DEPTH = 256;
  localparam int          WAITC = 1;
  localparam int          LAT   = 2;
  localparam int          LAT2  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic        reset;
  logic        cs, rn, wn;
  logic [1:0]  be;
  logic [31:0] addr;
  logic [15:0] wd;
  logic        wr_o, rdv, err;
  logic [15:0] rd, wc;

  logic        cs2, rn2, wn2;
  logic [1:0]  be2;
  logic [31:0] addr2;
  logic [15:0] wd2;
  logic        wr2, rdv2, err2;
  logic [15:0] rd2, wc2;

  avalon_word_responder #(.ADDR_BASE(BASE), .DEPTH(DEPTH),
                          .WAIT_CYCLES(WAITC), .READ_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .chipselect(cs), .byteenable(be),
    .read_n(rn), .write_n(wn), .address(addr), .writedata(wd),
    .waitrequest(wr_o), .readdatavalid(rdv), .readdata(rd),
    .write_count(wc), .err(err));

  avalon_word_responder #(.ADDR_BASE(BASE), .DEPTH(DEPTH),
                          .WAIT_CYCLES(0), .READ_LATENCY(LAT2)) dut2 (
    .clk(clk), .reset(reset), .chipselect(cs2), .byteenable(be2),
    .read_n(rn2), .write_n(wn2), .address(addr2), .writedata(wd2),
    .waitrequest(wr2), .readdatavalid(rdv2), .readdata(rd2),
    .write_count(wc2), .err(err2));

  // Reference model of the default instance: word array, counter, error.
  logic [15:0] m_mem [DEPTH];
  int          m_wc  = 0;
  bit          m_err = 0;

  typedef struct { logic [15:0] data; int due; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  function automatic bit m_in_range(input logic [31:0] a);
    if (a < BASE || a[0]) return 1'b0;
    return ((a - BASE) / 2) < DEPTH;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [15:0] d,
                                      input logic [1:0] b);
    int i;
    if (!m_in_range(a)) begin
      m_err = 1'b1;
      return;
    end
    i = int'((a - BASE) / 2);
    if (b[0]) m_mem[i][7:0]  = d[7:0];
    if (b[1]) m_mem[i][15:8] = d[15:8];
    if (m_wc < 65535) m_wc++;
  endfunction

  function automatic logic [15:0] model_read(input logic [31:0] a);
    if (!m_in_range(a)) begin
      m_err = 1'b1;
      return 16'hDEAD;
    end
    return m_mem[int'((a - BASE) / 2)];
  endfunction

  // Every readdatavalid pulse must match the oldest outstanding read, on
  // exactly the cycle it is due.
  always @(negedge clk) begin
    if (rdv === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rdv_unexpected cyc=%0d got data %h, required no pulse", cyc, rd);
      end else begin
        mon_e = exp_q.pop_front();
        if (rd !== mon_e.data || cyc != mon_e.due) begin
          errors++;
          $display("FAIL rd_data cyc=%0d got %h, required %h at cyc %0d",
                   cyc, rd, mon_e.data, mon_e.due);
        end
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog timeout at cyc %0d", cyc);
    $fatal(1);
  end

  task automatic idle(input int n);
    @(negedge clk);
    cs = 1'b0; rn = 1'b1; wn = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    cs = 1'b0; rn = 1'b1; wn = 1'b1;
    exp_q.delete();
    m_wc  = 0;
    m_err = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One request on the default instance, held until accepted. The number
  // of waitrequest cycles seen must equal WAITC.
  task automatic do_req(input bit is_rd, input logic [31:0] a, input logic [15:0] d,
                        input logic [1:0] b, input string nm);
    int   stalls;
    exp_t e;
    @(negedge clk);
    cs = 1'b1; rn = !is_rd; wn = is_rd; addr = a; wd = d; be = b;
    stalls = 0;
    #1;
    while (wr_o === 1'b1 && stalls <= 20) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    checks++;
    if (stalls != WAITC) begin
      errors++;
      $display("FAIL %s_stall got %0d cycles, required %0d", nm, stalls, WAITC);
      if (stalls > 20) return;
    end
    @(posedge clk);
    #1;
    if (is_rd) begin
      e.data = model_read(a);
      e.due  = cyc + LAT - 1;
      exp_q.push_back(e);
    end else begin
      model_write(a, d, b);
    end
  endtask

  task automatic drain(input string nm);
    idle(LAT + 2);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d reads outstanding, required 0", nm, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cs = 1'b1; rn = 1'b0; wn = 1'b1; addr = BASE; wd = 16'h0; be = 2'b11;
    cs2 = 1'b1; rn2 = 1'b0; wn2 = 1'b1; addr2 = BASE; wd2 = 16'h0; be2 = 2'b11;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (wr_o !== 1'b1) begin errors++; $display("FAIL reset_wait got %b, required 1", wr_o); end
    checks++; if (wr2 !== 1'b1) begin errors++; $display("FAIL reset_wait2 got %b, required 1", wr2); end
    checks++; if (rdv !== 1'b0) begin errors++; $display("FAIL reset_rdv got %b, required 0", rdv); end
    checks++; if (rd !== 16'h0) begin errors++; $display("FAIL reset_rd got %h, required 0000", rd); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b, required 0", err); end
    checks++; if (wc !== 16'h0) begin errors++; $display("FAIL reset_wc got %h, required 0000", wc); end
    @(negedge clk);
    cs = 1'b0; rn = 1'b1; wn = 1'b1;
    cs2 = 1'b0; rn2 = 1'b1; wn2 = 1'b1;
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    do_req(1'b0, BASE, 16'hBEEF, 2'b11, "wr1");
    do_req(1'b1, BASE, 16'h0, 2'b11, "rd1");
    drain("wr_rd");
    checks++; if (wc !== 16'(m_wc)) begin errors++; $display("FAIL wr_rd_wc got %0d, required %0d", wc, m_wc); end
    checks++; if (err !== m_err) begin errors++; $display("FAIL wr_rd_err got %b, required %b", err, m_err); end
  endtask

  task automatic test_byte_enables();
    do_req(1'b0, BASE + 32'd2, 16'h1234, 2'b11, "be_w1");
    do_req(1'b0, BASE + 32'd2, 16'hAB00, 2'b10, "be_w2");
    do_req(1'b1, BASE + 32'd2, 16'h0, 2'b00, "be_r1");
    do_req(1'b0, BASE + 32'd2, 16'hFFFF, 2'b00, "be_w3");
    do_req(1'b0, BASE + 32'd2, 16'h55C7, 2'b01, "be_w4");
    do_req(1'b1, BASE + 32'd2, 16'h0, 2'b11, "be_r2");
    drain("be");
    checks++; if (wc !== 16'(m_wc)) begin errors++; $display("FAIL be_wc got %0d, required %0d", wc, m_wc); end
  endtask

  task automatic test_streaming();
    int c0;
    int npulse;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cs2 = 1'b1; rn2 = 1'b1; wn2 = 1'b0; addr2 = BASE + 32'(2 * i); wd2 = 16'(i); be2 = 2'b11;
      #1;
      checks++;
      if (wr2 !== 1'b0) begin errors++; $display("FAIL stream_preload_wait got %b, required 0", wr2); end
    end
    c0 = 0;
    npulse = 0;
    for (int t = 0; t < 8 + LAT2 + 3; t++) begin
      @(negedge clk);
      if (t < 8) begin
        cs2 = 1'b1; rn2 = 1'b0; wn2 = 1'b1; addr2 = BASE + 32'(2 * t);
      end else begin
        cs2 = 1'b0; rn2 = 1'b1; wn2 = 1'b1;
      end
      if (t == 0) c0 = cyc;
      #1;
      if (t < 8) begin
        checks++;
        if (wr2 !== 1'b0) begin errors++; $display("FAIL stream_wait t=%0d got %b, required 0", t, wr2); end
      end
      if (rdv2 === 1'b1) begin
        checks++;
        if (rd2 !== 16'(npulse) || cyc != c0 + LAT2 + npulse) begin
          errors++;
          $display("FAIL stream_data got %h at cyc %0d, required %h at cyc %0d",
                   rd2, cyc, 16'(npulse), c0 + LAT2 + npulse);
        end
        npulse++;
      end
    end
    checks++; if (npulse != 8) begin errors++; $display("FAIL stream_count got %0d pulses, required 8", npulse); end
    checks++; if (wc2 !== 16'd8) begin errors++; $display("FAIL stream_wc got %0d, required 8", wc2); end
    checks++; if (err2 !== 1'b0) begin errors++; $display("FAIL stream_err got %b, required 0", err2); end
  endtask

  task automatic test_errors();
    apply_reset();
    do_req(1'b1, 32'd399_998, 16'h0, 2'b11, "err_rd_low");
    drain("err_rd");
    checks++; if (err !== m_err) begin errors++; $display("FAIL err_rd_flag got %b, required %b", err, m_err); end
    apply_reset();
    do_req(1'b0, BASE + 32'(2 * DEPTH), 16'h5555, 2'b11, "err_wr_high");
    do_req(1'b0, BASE + 32'd1, 16'h6666, 2'b11, "err_wr_odd");
    do_req(1'b1, BASE, 16'h0, 2'b11, "err_rd_base");
    drain("err_wr");
    checks++; if (wc !== 16'(m_wc)) begin errors++; $display("FAIL err_wr_wc got %0d, required %0d", wc, m_wc); end
    checks++; if (err !== m_err) begin errors++; $display("FAIL err_wr_flag got %b, required %b", err, m_err); end
    apply_reset();
    @(negedge clk);
    cs = 1'b1; rn = 1'b0; wn = 1'b0; addr = BASE; wd = 16'h7777; be = 2'b11;
    #1;
    checks++; if (wr_o !== 1'b0) begin errors++; $display("FAIL illegal_wait got %b, required 0", wr_o); end
    repeat (2) @(negedge clk);
    m_err = 1'b1;
    #1;
    checks++; if (err !== m_err) begin errors++; $display("FAIL illegal_err got %b, required %b", err, m_err); end
    checks++; if (wc !== 16'(m_wc)) begin errors++; $display("FAIL illegal_wc got %0d, required %0d", wc, m_wc); end
    do_req(1'b1, BASE, 16'h0, 2'b11, "illegal_rd_back");
    drain("illegal");
  endtask

  task automatic test_withdrawn();
    do_req(1'b0, BASE + 32'd4, 16'h1111, 2'b11, "wd_pre");
    apply_reset();
    @(negedge clk);
    cs = 1'b1; rn = 1'b1; wn = 1'b0; addr = BASE + 32'd4; wd = 16'h7777; be = 2'b11;
    #1;
    checks++; if (wr_o !== 1'b1) begin errors++; $display("FAIL wd_wr_stall got %b, required 1", wr_o); end
    @(negedge clk);
    cs = 1'b0;
    @(negedge clk);
    cs = 1'b1; rn = 1'b0; wn = 1'b1; addr = BASE + 32'd4;
    #1;
    checks++; if (wr_o !== 1'b1) begin errors++; $display("FAIL wd_rd_stall got %b, required 1", wr_o); end
    @(negedge clk);
    cs = 1'b0;
    do_req(1'b0, BASE + 32'd6, 16'h2222, 2'b11, "wd_next");
    do_req(1'b1, BASE + 32'd4, 16'h0, 2'b11, "wd_readback");
    drain("wd");
    checks++; if (wc !== 16'(m_wc)) begin errors++; $display("FAIL wd_wc got %0d, required %0d", wc, m_wc); end
  endtask

  task automatic test_reset_midflight();
    do_req(1'b0, BASE + 32'd8, 16'h2468, 2'b11, "mf_wr");
    do_req(1'b1, BASE + 32'd8, 16'h0, 2'b11, "mf_rd");
    apply_reset();
    repeat (LAT + 2) @(negedge clk);
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL mf_err got %b, required 0", err); end
    checks++; if (wc !== 16'h0) begin errors++; $display("FAIL mf_wc got %0d, required 0", wc); end
    do_req(1'b1, BASE + 32'd8, 16'h0, 2'b11, "mf_readback");
    drain("mf");
  endtask

  task automatic test_random();
    logic [31:0] a;
    int          k;
    apply_reset();
    for (int i = 0; i < 16; i++)
      do_req(1'b0, BASE + 32'(2 * i), 16'($urandom), 2'b11, "rnd_pre");
    for (int n = 0; n < 80; n++) begin
      k = $urandom_range(0, 9);
      case ($urandom_range(0, 2))
        0:       a = BASE - 32'(2 * $urandom_range(1, 100));
        1:       a = BASE + 32'(2 * DEPTH) + 32'(2 * $urandom_range(0, 100));
        default: a = BASE + 32'(2 * $urandom_range(0, 15)) + 32'd1;
      endcase
      if (k <= 3)      do_req(1'b1, BASE + 32'(2 * $urandom_range(0, 15)), 16'h0, 2'($urandom), "rnd_rd");
      else if (k <= 6) do_req(1'b0, BASE + 32'(2 * $urandom_range(0, 15)), 16'($urandom), 2'($urandom), "rnd_wr");
      else if (k == 7) do_req(1'b1, a, 16'h0, 2'b11, "rnd_rd_oor");
      else if (k == 8) do_req(1'b0, a, 16'($urandom), 2'b11, "rnd_wr_oor");
      else             idle($urandom_range(0, 2));
      checks++; if (wc !== 16'(m_wc)) begin errors++; $display("FAIL rnd_wc n=%0d got %0d, required %0d", n, wc, m_wc); end
      checks++; if (err !== m_err) begin errors++; $display("FAIL rnd_err n=%0d got %b, required %b", n, err, m_err); end
    end
    drain("rnd");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enables();
    test_streaming();
    test_errors();
    test_withdrawn();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
